adder_acc: RTL
==============

ADDER_ACC -- requirements
Module: adder_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand/result width in bits, legal range 2..32.
REQ-002 SHALL have parameter SATURATE, default 0: 1 = clamp results on overflow, 0 = wrap.
REQ-003 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port En  input  1  global enable; 0 freezes all state.
REQ-006 SHALL have port In_valid  input  1  operand/op presented.
REQ-007 SHALL have port In_ready  output  1  block can accept this cycle.
REQ-008 SHALL have port A  input  WIDTH  operand A.
REQ-009 SHALL have port B  input  WIDTH  operand B; ignored for ACC and CLR.
REQ-010 SHALL have port Op  input  2  00 ADD A+B, 01 SUB A-B, 10 ACC Acc+A, 11 CLR.
REQ-011 SHALL have port Signed  input  1  1 = two's-complement overflow rules, 0 = unsigned.
REQ-012 SHALL have port Clr_sticky  input  1  clears Sticky_ovf.
REQ-013 SHALL have port Sum  output  WIDTH  registered result.
REQ-014 SHALL have port Carry  output  1  raw bit WIDTH of the extended sum (SUB/ACC included).
REQ-015 SHALL have port Overflow  output  1  overflow of the result currently on Sum.
REQ-016 SHALL have port Sticky_ovf  output  1  latched overflow since last clear.
REQ-017 SHALL have port Out_valid  output  1  Sum/Carry/Overflow hold a result.
REQ-018 SHALL have port Out_ready  input  1  consumer takes the result.

Function
REQ-019 In_ready SHALL equal En & (~Out_valid | Out_ready), combinational.
REQ-020 An operation SHALL be accepted on a rising edge with In_valid & In_ready; result appears on Sum with Out_valid=1 exactly one cycle later.
REQ-021 SUB SHALL compute A + ~B + 1 in WIDTH+1 bits; Carry = bit WIDTH (1 = no borrow).
REQ-022 Unsigned overflow SHALL be: ADD/ACC carry out = 1; SUB borrow (A < B).
REQ-023 Signed overflow SHALL be: operands of equal sign (SUB: A vs ~B) and result sign differs.
REQ-024 With SATURATE=1 an overflowing result SHALL clamp: unsigned ADD/ACC to all ones, unsigned SUB to 0; signed to max positive if A >= 0, min negative otherwise; Overflow still asserted; Carry unchanged.
REQ-025 Internal accumulator Acc (WIDTH bits) SHALL update only on accepted ACC (to the post-clamp result) or CLR (to 0); ADD/SUB SHALL leave Acc unchanged.
REQ-026 CLR SHALL produce Sum=0, Carry=0, Overflow=0 with Out_valid=1.
REQ-027 Out_valid SHALL clear when Out_ready=1 and no new accept in the same cycle; accept plus dequeue in the same cycle SHALL keep Out_valid=1 with new data.
REQ-028 While Out_valid=1 and Out_ready=0, Sum, Carry, Overflow SHALL hold stable.
REQ-029 Sticky_ovf SHALL set on any accepted overflowing op; Clr_sticky clears it; simultaneous set and clear: set wins.
REQ-030 En=0 SHALL hold every register (Acc, outputs, Sticky_ovf, Out_valid) including Clr_sticky effect and dequeue.
REQ-031 ACC wrap-around with SATURATE=0 SHALL keep the low WIDTH bits in Acc.

Reset
REQ-032 Rst_n=0 SHALL immediately force Sum=0, Carry=0, Overflow=0, Sticky_ovf=0, Out_valid=0, Acc=0, regardless of Clk or En.
REQ-033 An operation in flight at reset SHALL be discarded; after Rst_n rises In_ready SHALL equal En.

Verification (WIDTH=4)
REQ-034 Unsigned ADD A=9 B=8 -> next cycle Sum=1, Carry=1, Overflow=1, Sticky_ovf=1, Out_valid=1.
REQ-035 Signed ADD A=7 B=1 -> SATURATE=0: Sum=8, Overflow=1; SATURATE=1: Sum=7, Overflow=1.
REQ-036 Unsigned SUB A=3 B=5 -> Sum=14, Carry=0, Overflow=1; SATURATE=1: Sum=0.
REQ-037 CLR, ACC 5, ACC 6, ACC 6 (unsigned, wrap) -> Sum 0, 5, 11, 1; last Overflow=1, Carry=1.
REQ-038 In_valid=1 every cycle, Out_ready=0 for 2 cycles after first accept -> In_ready=0, Sum held; second op accepted on first cycle Out_ready=1, none lost or duplicated.
REQ-039 Rst_n pulled low between edges while Out_valid=1, Sticky_ovf=1 -> all outputs 0 before next edge; subsequent ACC 2 -> Sum=2.

Source files
------------

// File: rtl/adder_acc.sv
`default_nettype none
// ==========================================================================
// adder_acc : registered ADD/SUB/ACC/CLR unit with valid/ready handshake,
//             wrap or saturating overflow, and a sticky overflow flag.
// Rev 1.0
// ==========================================================================
module adder_acc #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  input  logic             Signed,
  input  logic             Clr_sticky,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Sticky_ovf,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_ACC = 2'b10;
  localparam logic [1:0] c_OP_CLR = 2'b11;

  logic [WIDTH-1:0] sum_q, sum_d, acc_q, acc_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic             sticky_q, sticky_d, valid_q, valid_d;

  logic             w_accept, w_is_sub, w_is_clr;
  logic [WIDTH-1:0] w_x, w_y, w_raw, w_res;
  logic [WIDTH:0]   w_ext;
  logic             w_cout, w_ovf_u, w_ovf_s, w_ovf;

  assign In_ready = En & (~valid_q | Out_ready);
  assign w_accept = In_valid & In_ready;
  assign w_is_sub = (Op == c_OP_SUB);
  assign w_is_clr = (Op == c_OP_CLR);

  always_comb begin
    w_x     = (Op == c_OP_ACC) ? acc_q : A;
    w_y     = (Op == c_OP_ACC) ? A : (w_is_sub ? ~B : B);
    w_ext   = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_is_sub};
    w_raw   = w_ext[WIDTH-1:0];
    w_cout  = w_ext[WIDTH];
    w_ovf_u = w_is_sub ? ~w_cout : w_cout;
    w_ovf_s = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_raw[WIDTH-1] != w_x[WIDTH-1]);
    w_ovf   = ~w_is_clr & (Signed ? w_ovf_s : w_ovf_u);
    w_res   = w_raw;
    // Signed clamp direction follows A; for ACC, A and Acc share a sign whenever overflow occurs
    if (SATURATE && w_ovf) begin
      if (Signed) w_res = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else         w_res = w_is_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
    if (w_is_clr) w_res = '0;
  end

  always_comb begin
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    valid_d  = valid_q;
    if (En) begin
      if (w_accept) begin
        sum_d   = w_res;
        carry_d = w_cout & ~w_is_clr;
        ovf_d   = w_ovf;
        valid_d = 1'b1;
        if (Op == c_OP_ACC) acc_d = w_res;
        else if (w_is_clr)  acc_d = '0;
      end else if (Out_ready) begin
        valid_d = 1'b0;
      end
      if (w_accept && w_ovf) sticky_d = 1'b1;
      else if (Clr_sticky)   sticky_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      valid_q  <= valid_d;
    end
  end

  assign Sum        = sum_q;
  assign Carry      = carry_q;
  assign Overflow   = ovf_q;
  assign Sticky_ovf = sticky_q;
  assign Out_valid  = valid_q;

  // c_OP_ADD is the default path of the operand mux
  logic w_unused;
  assign w_unused = (Op == c_OP_ADD);

endmodule
`default_nettype wire
